// File: rtl/fs_accel_wback_ctrl_if.sv
// Memory write port of the WBACK stage: simple valid/ready byte-lane write.
// The controller drives the request (master); the memory side drives ready (slave).
interface fs_accel_wback_ctrl_if;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  modport master (output mem_wvalid, output mem_waddr, output mem_wdata,
                  output mem_wstrb, input mem_wready);
  modport slave  (input mem_wvalid, input mem_waddr, input mem_wdata,
                  input mem_wstrb, output mem_wready);
endinterface

// File: rtl/fs_accel_wback_ctrl.sv
// WBACK stage controller: captures finished output bytes from POOL under the shared
// pipeline-advance condition and issues one byte-lane memory write per output.
module fs_accel_wback_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enb,
  input  logic [3:0]  cfg_layer_typ,
  input  logic        RDATA_rdy,
  input  logic        RDATA_fin,
  input  logic        COMPS_rdy,
  input  logic        COMPS_fin,
  input  logic        POOL_rdy,
  input  logic        POOL_fin,
  input  logic        POOL_is_out_fin,
  input  logic        POOL_ignore,
  input  logic [31:0] POOL_o_addr,
  input  logic [7:0]  pool_o_data,
  fs_accel_wback_ctrl_if.master mem,
  output logic        WBACK_start,
  output logic        WBACK_rdy,
  output logic        WBACK_fin,
  output logic [31:0] wb_cnt
);
  localparam logic [3:0] LT_MIXED = 4'd2;

  typedef enum logic [1:0] {W_START, W_WAIT, W_WRITE, W_FINISH} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_data;
  logic [31:0] r_cnt;
  logic        r_start, r_rdy, r_fin, r_wvalid;

  logic w_up_ok, w_do_wr, w_wb_reg_enb;

  assign w_up_ok      = (RDATA_rdy | RDATA_fin) & (COMPS_rdy | COMPS_fin) & (POOL_rdy | POOL_fin);
  assign w_wb_reg_enb = w_up_ok & r_rdy & enb;
  // Odd-size pooling slots are only dropped for MIXED layers.
  assign w_do_wr      = POOL_is_out_fin & ~((cfg_layer_typ == LT_MIXED) & POOL_ignore);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= W_START;
      r_addr   <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_start  <= 1'b1;
      r_rdy    <= 1'b0;
      r_fin    <= 1'b0;
      r_wvalid <= 1'b0;
    end else if (enb) begin
      case (r_state)
        W_START: if (w_up_ok) begin
          r_state <= W_WAIT;
          r_start <= 1'b0;
          r_rdy   <= 1'b1;
        end
        W_WAIT: if (w_wb_reg_enb) begin
          // End of layer beats a coincident output; that slot is discarded.
          if (POOL_fin) begin
            r_state <= W_FINISH;
            r_rdy   <= 1'b0;
            r_fin   <= 1'b1;
          end else if (w_do_wr) begin
            r_state  <= W_WRITE;
            r_addr   <= POOL_o_addr;
            r_data   <= pool_o_data;
            r_rdy    <= 1'b0;
            r_wvalid <= 1'b1;
          end
        end
        W_WRITE: if (mem.mem_wready) begin
          r_state  <= W_WAIT;
          r_cnt    <= r_cnt + 32'd1;
          r_wvalid <= 1'b0;
          r_rdy    <= 1'b1;
        end
        W_FINISH: ;
        default: begin
          r_state  <= W_START;
          r_start  <= 1'b1;
          r_rdy    <= 1'b0;
          r_fin    <= 1'b0;
          r_wvalid <= 1'b0;
        end
      endcase
    end
  end

  assign WBACK_start    = r_start;
  assign WBACK_rdy      = r_rdy;
  assign WBACK_fin      = r_fin;
  assign wb_cnt         = r_cnt;
  assign mem.mem_wvalid = r_wvalid;
  assign mem.mem_waddr  = {r_addr[31:2], 2'b00};
  assign mem.mem_wdata  = {4{r_data}};
  assign mem.mem_wstrb  = 4'b0001 << r_addr[1:0];
endmodule

// File: tb/tb_fs_accel_wback_ctrl.sv
// Bench for fs_accel_wback_ctrl: directed plan items plus random traffic against a
// transaction-level model (started/done flags and a pending-write slot).
module tb_fs_accel_wback_ctrl;
  logic        clk = 1'b0;
  logic        resetn, enb;
  logic [3:0]  cfg_layer_typ;
  logic        RDATA_rdy, RDATA_fin, COMPS_rdy, COMPS_fin, POOL_rdy, POOL_fin;
  logic        POOL_is_out_fin, POOL_ignore;
  logic [31:0] POOL_o_addr;
  logic [7:0]  pool_o_data;
  logic        WBACK_start, WBACK_rdy, WBACK_fin;
  logic [31:0] wb_cnt;

  fs_accel_wback_ctrl_if mem_if();

  fs_accel_wback_ctrl dut (
    .clk(clk), .resetn(resetn), .enb(enb), .cfg_layer_typ(cfg_layer_typ),
    .RDATA_rdy(RDATA_rdy), .RDATA_fin(RDATA_fin), .COMPS_rdy(COMPS_rdy),
    .COMPS_fin(COMPS_fin), .POOL_rdy(POOL_rdy), .POOL_fin(POOL_fin),
    .POOL_is_out_fin(POOL_is_out_fin), .POOL_ignore(POOL_ignore),
    .POOL_o_addr(POOL_o_addr), .pool_o_data(pool_o_data), .mem(mem_if.master),
    .WBACK_start(WBACK_start), .WBACK_rdy(WBACK_rdy), .WBACK_fin(WBACK_fin),
    .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Model: pipeline has started, layer is done, a write is outstanding.
  bit          m_started, m_done, m_pending;
  logic [31:0] m_addr;
  logic [7:0]  m_data;
  logic [31:0] m_cnt;

  function automatic void m_reset();
    m_started = 0; m_done = 0; m_pending = 0;
    m_addr = '0; m_data = '0; m_cnt = '0;
  endfunction

  function automatic void m_step();
    bit up;
    if (!resetn) begin m_reset(); return; end
    if (!enb) return;
    up = (RDATA_rdy | RDATA_fin) & (COMPS_rdy | COMPS_fin) & (POOL_rdy | POOL_fin);
    if (!m_started) begin
      if (up) m_started = 1;
    end else if (m_done) begin
    end else if (m_pending) begin
      if (mem_if.mem_wready) begin m_pending = 0; m_cnt = m_cnt + 1; end
    end else if (up) begin
      if (POOL_fin) m_done = 1;
      else if (POOL_is_out_fin && !(cfg_layer_typ == 4'd2 && POOL_ignore)) begin
        m_addr = POOL_o_addr; m_data = pool_o_data; m_pending = 1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".start"}, WBACK_start, !m_started);
    chk({tag, ".rdy"},   WBACK_rdy,   m_started && !m_done && !m_pending);
    chk({tag, ".fin"},   WBACK_fin,   m_done);
    chk({tag, ".wvld"},  mem_if.mem_wvalid, m_pending);
    chk({tag, ".waddr"}, mem_if.mem_waddr, {m_addr[31:2], 2'b00});
    chk({tag, ".wdata"}, mem_if.mem_wdata, {4{m_data}});
    chk({tag, ".wstrb"}, mem_if.mem_wstrb, 4'b0001 << m_addr[1:0]);
    chk({tag, ".cnt"},   wb_cnt, m_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all(tag);
  endtask

  // Reset pulse between edges: outputs must fall back immediately.
  task automatic async_rst(input string tag);
    resetn = 1'b0;
    m_reset();
    #1 check_all(tag);
    #1 resetn = 1'b1;
  endtask

  task automatic pipe_idle();
    RDATA_rdy = 1; RDATA_fin = 0; COMPS_rdy = 1; COMPS_fin = 0;
    POOL_rdy = 1; POOL_fin = 0; POOL_is_out_fin = 0; POOL_ignore = 0;
  endtask

  initial begin
    resetn = 1'b1; enb = 1'b1; cfg_layer_typ = 4'd0;
    RDATA_rdy = 0; RDATA_fin = 0; COMPS_rdy = 0; COMPS_fin = 0;
    POOL_rdy = 0; POOL_fin = 0; POOL_is_out_fin = 0; POOL_ignore = 0;
    POOL_o_addr = 32'h0; pool_o_data = 8'h0; mem_if.mem_wready = 1'b0;
    m_reset();
    #1 resetn = 1'b0;
    @(negedge clk);
    check_all("rst");
    pipe_idle();
    step("rst_hold");
    chk("rst.wstrb", mem_if.mem_wstrb, 4'b0001);
    resetn = 1'b1;
    step("start");
    chk("start.rdy", WBACK_rdy, 1'b1);

    // CONV write with ready already high
    POOL_o_addr = 32'h1003; pool_o_data = 8'hA5; POOL_is_out_fin = 1; mem_if.mem_wready = 1;
    step("conv_cap");
    chk("conv.waddr", mem_if.mem_waddr, 32'h1000);
    chk("conv.wstrb", mem_if.mem_wstrb, 4'b1000);
    chk("conv.wdata", mem_if.mem_wdata, 32'hA5A5A5A5);
    POOL_is_out_fin = 0;
    step("conv_done");
    chk("conv.cnt", wb_cnt, 32'd1);

    // Back-pressure: ready low 5 cycles, request must hold while inputs change
    POOL_o_addr = 32'h2001; pool_o_data = 8'h3C; POOL_is_out_fin = 1; mem_if.mem_wready = 0;
    step("bp_cap");
    for (int i = 0; i < 5; i++) begin
      POOL_o_addr = $urandom; pool_o_data = 8'($urandom);
      step("bp_hold");
      chk("bp.waddr", mem_if.mem_waddr, 32'h2000);
    end
    POOL_is_out_fin = 0; mem_if.mem_wready = 1;
    step("bp_done");
    chk("bp.cnt", wb_cnt, 32'd2);

    // MIXED drops ignored slots, DENSE does not
    cfg_layer_typ = 4'd2; POOL_ignore = 1; POOL_is_out_fin = 1; POOL_o_addr = 32'h3002;
    step("mixed_ign");
    step("mixed_ign2");
    chk("mixed.wvld", mem_if.mem_wvalid, 1'b0);
    cfg_layer_typ = 4'd1;
    step("dense_cap");
    chk("dense.wvld", mem_if.mem_wvalid, 1'b1);
    POOL_is_out_fin = 0; POOL_ignore = 0;

    // Stalled by enb=0 while ready is high
    enb = 0;
    step("enb_hold");
    step("enb_hold2");
    chk("enb.cnt", wb_cnt, 32'd2);
    enb = 1;
    step("enb_done");
    chk("enb.cnt2", wb_cnt, 32'd3);

    // POOL_fin wins over a coincident output
    cfg_layer_typ = 4'd0; POOL_fin = 1; POOL_is_out_fin = 1;
    step("fin");
    chk("fin.fin", WBACK_fin, 1'b1);
    POOL_fin = 0;
    step("fin_stay");
    step("fin_stay2");

    // Reset pulse in the middle of a stalled write
    async_rst("rst2");
    step("rst2_start");
    POOL_is_out_fin = 1; mem_if.mem_wready = 0; POOL_o_addr = 32'h40; pool_o_data = 8'h77;
    step("mid_cap");
    step("mid_hold");
    async_rst("mid_rst");
    chk("mid.wvld", mem_if.mem_wvalid, 1'b0);
    POOL_is_out_fin = 0;
    step("mid_after");

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 59) == 0) async_rst("rnd_rst");
      enb             = ($urandom_range(0, 7) != 0);
      cfg_layer_typ   = 4'($urandom_range(0, 4));
      RDATA_rdy       = ($urandom_range(0, 4) != 0);
      RDATA_fin       = ($urandom_range(0, 5) == 0);
      COMPS_rdy       = ($urandom_range(0, 4) != 0);
      COMPS_fin       = ($urandom_range(0, 5) == 0);
      POOL_rdy        = ($urandom_range(0, 4) != 0);
      POOL_fin        = ($urandom_range(0, 40) == 0);
      POOL_is_out_fin = ($urandom_range(0, 2) != 0);
      POOL_ignore     = ($urandom_range(0, 2) == 0);
      POOL_o_addr     = $urandom;
      pool_o_data     = 8'($urandom);
      mem_if.mem_wready = ($urandom_range(0, 2) != 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
